// File: rtl/card_pkg.sv
// Shared types and helpers for the card deck: deck geometry, card record,
// draw FSM states and index-to-card decoding.
package card_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;
  localparam int unsigned SUITS     = 4;

  typedef struct packed {
    logic [3:0] number;
    logic [1:0] symbol;
  } card_t;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    DONE
  } deck_state_t;

  // Deck index 0..51 -> rank 1..13 and suit 0..3
  function automatic card_t idx_to_card(input logic [5:0] idx);
    card_t c;
    c.number = 4'(idx % 6'(RANKS)) + 4'd1;
    c.symbol = 2'(idx / 6'(RANKS));
    return c;
  endfunction

endpackage

// File: rtl/card_deck_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// A zero seed would lock the register, so it is replaced by 8'h01.
module card_lfsr #(
  parameter logic [7:0] SEED = 8'hB7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] lfsr
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feedback from the tap bits into bit 0
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/card_deck.sv
// Card deck for the blackjack game FSM: deals one card per request, drawn
// without replacement from 52 cards tracked in a used-card bitmap.
// Build option CARD_DECK_ORDERED_EN: deal in fixed order from a draw counter
// instead of the free-running LFSR.
module card_deck #(
  parameter logic [7:0] LFSR_SEED = 8'hB7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card_number,
  output logic [1:0] card_symbol,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  import card_pkg::*;

  deck_state_t state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  left_q, left_d;
  card_t       card_q, card_d;
  logic [7:0]  lfsr;
  logic [5:0]  cand_idx;
  logic        lfsr_unused;

  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr)
  );

`ifdef CARD_DECK_ORDERED_EN
  logic [5:0] cnt_q, cnt_d;

  assign cand_idx    = cnt_q;
  assign lfsr_unused = ^lfsr;

  // Draw counter: next sequential index, restarts on shuffle
  always_comb begin
    cnt_d = cnt_q;
    if (shuffle) begin
      cnt_d = '0;
    end else if (state_q == PICK && !used_q[idx_q]) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Draw counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Fold 52..63 back into range so every LFSR value maps to a deck slot
  assign cand_idx    = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];
  assign lfsr_unused = ^lfsr[7:6];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; shuffle forces IDLE from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req && left_q != '0) state_d = PICK;
      PICK: if (!used_q[idx_q])      state_d = DONE;
      DONE:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
    if (shuffle) begin
      state_d = IDLE;
    end
  end

  // Deck datapath: latch candidate, linear probe, mark used, register card
  always_comb begin
    idx_d  = idx_q;
    used_d = used_q;
    left_d = left_q;
    card_d = card_q;
    if (shuffle) begin
      used_d = '0;
      left_d = 6'(DECK_SIZE);
    end else begin
      unique case (state_q)
        IDLE: if (req && left_q != '0) idx_d = cand_idx;
        PICK: begin
          if (!used_q[idx_q]) begin
            used_d[idx_q] = 1'b1;
            left_d        = left_q - 6'd1;
            card_d        = idx_to_card(idx_q);
          end else begin
            idx_d = (idx_q == 6'(DECK_SIZE - 1)) ? '0 : idx_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Deck datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      used_q <= '0;
      left_q <= 6'(DECK_SIZE);
      card_q <= '0;
    end else begin
      idx_q  <= idx_d;
      used_q <= used_d;
      left_q <= left_d;
      card_q <= card_d;
    end
  end

  // Outputs decoded from state and registered deck data
  always_comb begin
    card_valid  = (state_q == DONE);
    busy        = (state_q != IDLE);
    deck_empty  = (left_q == '0);
    cards_left  = left_q;
    card_number = card_q.number;
    card_symbol = card_q.symbol;
  end

endmodule
